// File: rtl/dcache_nway_wb.sv
// N-way set-associative write-back / write-allocate data cache.
// One outstanding pipeline request at a time. Misses run through a small FSM:
// an optional dirty-victim writeback, then a block fill.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | accepting requests; hits complete here with one-cycle latency
// S_WB        | writing the dirty victim block back to memory
// S_FILL_REQ  | requesting the missing block from memory
// S_FILL_WAIT | waiting for fill data; installs the block on arrival
// S_RESP      | miss response cycle (resp_valid high), then back to idle
module dcache_nway_wb #(
   parameter int NWAYS      = 2,
   parameter int NSETS      = 512,
   parameter int WIDTH      = 32,
   parameter int BLK_WORDS  = 2,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_wr,
   input  logic [ADDR_WIDTH-1:0]        req_addr,
   input  logic [WIDTH-1:0]             req_wdata,
   output logic                         resp_valid,
   output logic [WIDTH-1:0]             resp_rdata,
   output logic                         resp_hit,
   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic                         mem_req_wr,
   output logic [ADDR_WIDTH-1:0]        mem_req_addr,
   output logic [BLK_WORDS*WIDTH-1:0]   mem_wdata,
   input  logic                         mem_resp_valid,
   input  logic [BLK_WORDS*WIDTH-1:0]   mem_rdata
);

   localparam int OFF  = $clog2(BLK_WORDS * 4);
   localparam int IDXW = $clog2(NSETS);
   localparam int TAGW = ADDR_WIDTH - OFF - IDXW;
   localparam int WSW  = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam int WAYW = (NWAYS > 1) ? $clog2(NWAYS) : 1;
   localparam int BLKW = BLK_WORDS * WIDTH;
   localparam logic [WAYW-1:0] AGE_MAX = WAYW'(NWAYS - 1);

   typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL_REQ, S_FILL_WAIT, S_RESP} state_t;

   state_t state_q, state_d;

   // tag/data arrays carry no reset; valid gates every use of them
   logic [TAGW-1:0]  tag_mem  [NSETS][NWAYS];
   logic [BLKW-1:0]  data_mem [NSETS][NWAYS];
   logic [NWAYS-1:0] valid_q  [NSETS];
   logic [NWAYS-1:0] dirty_q  [NSETS];
   logic [WAYW-1:0]  age_q    [NSETS][NWAYS];

   logic [IDXW-1:0]  req_idx;
   logic [TAGW-1:0]  req_tag;
   logic [WSW-1:0]   req_wsel;
   logic             unused_lsb;

   logic [NWAYS-1:0] match_vec;
   logic             hit;
   logic [WAYW-1:0]  hit_way;
   logic [BLKW-1:0]  hit_blk;
   logic [WIDTH-1:0] hit_word;
   logic             hit_acc, miss_acc;

   logic [WAYW-1:0]  vic_sel;
   logic             vic_dirty;

   logic [TAGW-1:0]  lat_tag;
   logic [IDXW-1:0]  lat_idx;
   logic [WSW-1:0]   lat_wsel;
   logic             lat_wr;
   logic [WIDTH-1:0] lat_wdata;
   logic [WAYW-1:0]  vic_way;

   logic             wb_done, fill_en;
   logic [BLKW-1:0]  fill_blk;
   logic [WIDTH-1:0] fill_word;

   logic             touch_en;
   logic [IDXW-1:0]  touch_idx;
   logic [WAYW-1:0]  touch_way;
   logic [WAYW-1:0]  touch_old;

   assign req_idx    = req_addr[OFF +: IDXW];
   assign req_tag    = req_addr[OFF+IDXW +: TAGW];
   assign unused_lsb = ^req_addr[1:0];

   if (BLK_WORDS > 1) begin : g_wsel
      assign req_wsel = req_addr[2 +: WSW];
   end else begin : g_wsel_single
      assign req_wsel = 1'b0;
   end

   // Per-way tag match for the incoming request
   always_comb begin
      match_vec = '0;
      for (int w = 0; w < NWAYS; w++)
         match_vec[w] = valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag);
   end

   // Encode the matching way
   always_comb begin
      hit_way = '0;
      for (int w = 0; w < NWAYS; w++)
         if (match_vec[w]) hit_way = WAYW'(w);
   end

   assign hit      = |match_vec;
   assign hit_acc  = (state_q == S_IDLE) && req_valid && hit;
   assign miss_acc = (state_q == S_IDLE) && req_valid && !hit;
   assign hit_blk  = data_mem[req_idx][hit_way];
   assign hit_word = hit_blk[int'(req_wsel)*WIDTH +: WIDTH];

   // Victim choice: lowest invalid way, otherwise the oldest way (ties to lowest index)
   always_comb begin
      logic            found;
      logic [WAYW-1:0] best;
      vic_sel = '0;
      found   = 1'b0;
      best    = '0;
      for (int w = 0; w < NWAYS; w++)
         if (!found && !valid_q[req_idx][w]) begin
            found   = 1'b1;
            vic_sel = WAYW'(w);
         end
      if (!found) begin
         best = age_q[req_idx][0];
         for (int w = 1; w < NWAYS; w++)
            if (age_q[req_idx][w] > best) begin
               best    = age_q[req_idx][w];
               vic_sel = WAYW'(w);
            end
      end
   end

   assign vic_dirty = valid_q[req_idx][vic_sel] && dirty_q[req_idx][vic_sel];

   // Fill block with store data merged into the requested word
   always_comb begin
      fill_blk = mem_rdata;
      if (lat_wr) fill_blk[int'(lat_wsel)*WIDTH +: WIDTH] = lat_wdata;
   end

   assign fill_word = mem_rdata[int'(lat_wsel)*WIDTH +: WIDTH];

   assign touch_en  = hit_acc || fill_en;
   assign touch_idx = fill_en ? lat_idx : req_idx;
   assign touch_way = fill_en ? vic_way : hit_way;
   assign touch_old = age_q[touch_idx][touch_way];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next state and memory-side outputs
   always_comb begin
      state_d       = state_q;
      mem_req_valid = 1'b0;
      mem_req_wr    = 1'b0;
      mem_req_addr  = '0;
      mem_wdata     = '0;
      wb_done       = 1'b0;
      fill_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (miss_acc) state_d = vic_dirty ? S_WB : S_FILL_REQ;
         end
         S_WB: begin
            mem_req_valid = 1'b1;
            mem_req_wr    = 1'b1;
            mem_req_addr  = {tag_mem[lat_idx][vic_way], lat_idx, {OFF{1'b0}}};
            mem_wdata     = data_mem[lat_idx][vic_way];
            if (mem_req_ready) begin
               wb_done = 1'b1;
               state_d = S_FILL_REQ;
            end
         end
         S_FILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {lat_tag, lat_idx, {OFF{1'b0}}};
            if (mem_req_ready) state_d = S_FILL_WAIT;
         end
         S_FILL_WAIT: begin
            if (mem_resp_valid) begin
               fill_en = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);

   // Latch the missing request and its victim way
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_tag   <= '0;
         lat_idx   <= '0;
         lat_wsel  <= '0;
         lat_wr    <= 1'b0;
         lat_wdata <= '0;
         vic_way   <= '0;
      end else if (miss_acc) begin
         lat_tag   <= req_tag;
         lat_idx   <= req_idx;
         lat_wsel  <= req_wsel;
         lat_wr    <= req_wr;
         lat_wdata <= req_wdata;
         vic_way   <= vic_sel;
      end
   end

   // Valid, dirty and LRU age state.
   // Ages start all-zero after reset; ways at or below the touched way's old age
   // are aged (saturating), which converges to a proper age permutation as the
   // set fills and is identical to the strict-younger rule once it has.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NSETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < NWAYS; w++) age_q[s][w] <= '0;
         end
      end else begin
         if (touch_en) begin
            for (int w = 0; w < NWAYS; w++) begin
               if (WAYW'(w) == touch_way)
                  age_q[touch_idx][w] <= '0;
               else if (age_q[touch_idx][w] <= touch_old && age_q[touch_idx][w] != AGE_MAX)
                  age_q[touch_idx][w] <= age_q[touch_idx][w] + 1'b1;
            end
         end
         if (hit_acc && req_wr) dirty_q[req_idx][hit_way] <= 1'b1;
         if (wb_done) dirty_q[lat_idx][vic_way] <= 1'b0;
         if (fill_en) begin
            valid_q[lat_idx][vic_way] <= 1'b1;
            dirty_q[lat_idx][vic_way] <= lat_wr;
         end
      end
   end

   // Tag and data array writes: store hits and block fills
   always_ff @(posedge clk) begin
      if (hit_acc && req_wr)
         data_mem[req_idx][hit_way][int'(req_wsel)*WIDTH +: WIDTH] <= req_wdata;
      if (fill_en) begin
         tag_mem[lat_idx][vic_way]  <= lat_tag;
         data_mem[lat_idx][vic_way] <= fill_blk;
      end
   end

   // Pipeline response: hits answer from idle, misses on the fill edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_hit   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         if (hit_acc) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_rdata <= req_wr ? '0 : hit_word;
         end else if (fill_en) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_rdata <= lat_wr ? '0 : fill_word;
         end
      end
   end

   // A tag may live in at most one way of a set
   a_unique_tag: assert property (@(posedge clk) disable iff (!rst)
      (state_q == S_IDLE && req_valid) |-> $onehot0(match_vec));

endmodule

// File: tb/tb_dcache_nway_wb.sv
// Directed bench for dcache_nway_wb (2 ways, 4 sets, 2-word blocks).
// Stimulus pushes expected responses and memory requests into queues; a monitor
// pops and compares them when the DUT presents them. A behavioural memory
// answers fills with a fixed address-derived pattern.
module tb_dcache_nway_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_hit;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_wr;
   logic [31:0] mem_req_addr;
   logic [63:0] mem_wdata;
   logic        mem_resp_valid = 1'b0;
   logic [63:0] mem_rdata = '0;

   always #5 clk = ~clk;

   dcache_nway_wb #(
      .NWAYS(2), .NSETS(4), .WIDTH(32), .BLK_WORDS(2), .ADDR_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   typedef struct { logic [31:0] rdata; logic hit; } resp_t;
   typedef struct { logic wr; logic [31:0] addr; logic [63:0] wdata; } mreq_t;

   resp_t exp_resp[$];
   mreq_t exp_mem[$];
   int total = 0;
   int bad = 0;
   int n_resp = 0;
   int n_mem = 0;
   int want_resp = 0;
   int want_mem = 0;
   int stall_left = 0;
   bit hold_fill = 1'b0;
   bit pend_fill = 1'b0;
   logic [31:0] pend_addr = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] blk(input logic [31:0] a);
      if (a == 32'h100) return {32'h0000_BBBB, 32'h0000_AAAA};
      return {a + 32'h2000_0000, a + 32'h1000_0000};
   endfunction

   task automatic push_resp(input logic [31:0] d, input logic h);
      resp_t r;
      r.rdata = d;
      r.hit   = h;
      exp_resp.push_back(r);
      want_resp++;
   endtask

   task automatic push_mem(input logic wr, input logic [31:0] a, input logic [63:0] d);
      mreq_t m;
      m.wr    = wr;
      m.addr  = a;
      m.wdata = d;
      exp_mem.push_back(m);
      want_mem++;
   endtask

   // Memory model: drives just after the rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         if (!rst) begin
            pend_fill = 1'b0;
         end else if (pend_fill) begin
            if (!hold_fill) begin
               mem_resp_valid = 1'b1;
               mem_rdata      = blk(pend_addr);
               pend_fill      = 1'b0;
            end
         end else if (mem_req_valid) begin
            if (stall_left > 0) stall_left--;
            else begin
               mem_req_ready = 1'b1;
               if (!mem_req_wr) begin
                  pend_fill = 1'b1;
                  pend_addr = mem_req_addr;
               end
            end
         end
      end
   end

   // Monitor: compares DUT responses and accepted memory requests to the queues
   always @(negedge clk) begin
      resp_t er;
      mreq_t em;
      if (rst) begin
         if (resp_valid) begin
            n_resp++;
            if (exp_resp.size() == 0) begin
               total++; bad++;
               $display("FAIL resp_unexpected: got rdata=%h hit=%b want none", resp_rdata, resp_hit);
            end else begin
               er = exp_resp.pop_front();
               check("resp_rdata", 64'(resp_rdata), 64'(er.rdata));
               check("resp_hit", 64'(resp_hit), 64'(er.hit));
            end
         end
         if (mem_req_valid && mem_req_ready) begin
            n_mem++;
            if (exp_mem.size() == 0) begin
               total++; bad++;
               $display("FAIL mem_unexpected: got wr=%b addr=%h want none", mem_req_wr, mem_req_addr);
            end else begin
               em = exp_mem.pop_front();
               check("mem_wr", 64'(mem_req_wr), 64'(em.wr));
               check("mem_addr", 64'(mem_req_addr), 64'(em.addr));
               if (em.wr) check("mem_wdata", mem_wdata, em.wdata);
            end
         end
      end
   end

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      req_wr    = 1'b0;
   endtask

   task automatic wait_resp();
      int cyc;
      cyc = 0;
      while (n_resp < want_resp && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("resp_count", 64'(n_resp), 64'(want_resp));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      check({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
      check({tag, "_resp_hit"}, 64'(resp_hit), 64'd0);
      check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
      check({tag, "_mem_req_wr"}, 64'(mem_req_wr), 64'd0);
      check({tag, "_mem_req_addr"}, 64'(mem_req_addr), 64'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: cold load, then hit on the other word of the block
      push_mem(1'b0, 32'h100, '0);
      push_resp(32'h0000_AAAA, 1'b0);
      issue(1'b0, 32'h100, '0);
      check("miss_busy", 64'(req_ready), 64'd0);
      wait_resp();
      push_resp(32'h0000_BBBB, 1'b1);
      issue(1'b0, 32'h104, '0);
      check("hit_lat_load", 64'(resp_valid), 64'd1);
      wait_resp();

      // 2: store hit, load it back, then back-to-back hits
      push_resp(32'h0, 1'b1);
      issue(1'b1, 32'h100, 32'h0000_5A5A);
      check("hit_lat_store", 64'(resp_valid), 64'd1);
      push_resp(32'h0000_5A5A, 1'b1);
      issue(1'b0, 32'h100, '0);
      wait_resp();
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h104;
      push_resp(32'h0000_BBBB, 1'b1);
      @(negedge clk);
      check("b2b_ready", 64'(req_ready), 64'd1);
      check("b2b_resp1", 64'(resp_valid), 64'd1);
      req_addr = 32'h100;
      push_resp(32'h0000_5A5A, 1'b1);
      @(negedge clk);
      check("b2b_resp2", 64'(resp_valid), 64'd1);
      req_valid = 1'b0;
      wait_resp();

      // 3: fill second way, then evict the dirty LRU line 0x100
      push_mem(1'b0, 32'h200, '0);
      push_resp(32'h1000_0200, 1'b0);
      issue(1'b0, 32'h200, '0);
      wait_resp();
      push_mem(1'b1, 32'h100, {32'h0000_BBBB, 32'h0000_5A5A});
      push_mem(1'b0, 32'h300, '0);
      push_resp(32'h1000_0300, 1'b0);
      issue(1'b0, 32'h300, '0);
      wait_resp();

      // 4: clean victim (0x200) -> fill only
      push_mem(1'b0, 32'h400, '0);
      push_resp(32'h2000_0400, 1'b0);
      issue(1'b0, 32'h404, '0);
      wait_resp();

      // store miss into set 1 merges the store word; both words read back
      push_mem(1'b0, 32'h108, '0);
      push_resp(32'h0, 1'b0);
      issue(1'b1, 32'h10C, 32'h1234_5678);
      wait_resp();
      push_resp(32'h1000_0108, 1'b1);
      issue(1'b0, 32'h108, '0);
      push_resp(32'h1234_5678, 1'b1);
      issue(1'b0, 32'h10C, '0);
      wait_resp();

      // 5: memory stalls the fill request for 5 cycles
      stall_left = 5;
      push_mem(1'b0, 32'h500, '0);
      push_resp(32'h1000_0500, 1'b0);
      issue(1'b0, 32'h500, '0);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 64'(mem_req_valid), 64'd1);
         check("stall_addr", 64'(mem_req_addr), 64'h500);
         check("stall_wr", 64'(mem_req_wr), 64'd0);
         check("stall_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      wait_resp();

      // 6: reset while waiting for fill data
      hold_fill = 1'b1;
      push_mem(1'b0, 32'h600, '0);
      issue(1'b0, 32'h600, '0);
      cyc = 0;
      while (n_mem < want_mem && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("fill_req_seen", 64'(n_mem), 64'(want_mem));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(negedge clk);
      hold_fill = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      push_mem(1'b0, 32'h100, '0);
      push_resp(32'h0000_AAAA, 1'b0);
      issue(1'b0, 32'h100, '0);
      wait_resp();
      repeat (5) @(negedge clk);

      check("resp_queue_left", 64'(exp_resp.size()), 64'd0);
      check("mem_queue_left", 64'(exp_mem.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
